// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium stream-cipher core.
// Holds the state/key/IV geometry, the warm-up length, the FSM state encoding
// and the 0-based bit positions of the Trivium taps (sN in the cipher
// description lives at bit N-1 of the 288-bit state vector).
package trivium_pkg;

   localparam int unsigned STATE_W       = 288;
   localparam int unsigned KEY_BITS      = 80;
   localparam int unsigned IV_BITS       = 80;
   localparam int unsigned LOAD_BITS     = KEY_BITS + IV_BITS;
   localparam int unsigned WARMUP_ROUNDS = 1152;

   // IV bit 1 lands on s94; the gap between the last key bit (s80) and s94.
   localparam int unsigned IV_BASE = 93;
   localparam int unsigned IV_GAP  = IV_BASE - KEY_BITS;

   // Tap positions, 0-based.
   localparam int unsigned S66  = 65;
   localparam int unsigned S69  = 68;
   localparam int unsigned S91  = 90;
   localparam int unsigned S92  = 91;
   localparam int unsigned S93  = 92;
   localparam int unsigned S162 = 161;
   localparam int unsigned S171 = 170;
   localparam int unsigned S175 = 174;
   localparam int unsigned S176 = 175;
   localparam int unsigned S177 = 176;
   localparam int unsigned S243 = 242;
   localparam int unsigned S264 = 263;
   localparam int unsigned S286 = 285;
   localparam int unsigned S287 = 286;
   localparam int unsigned S288 = 287;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLoad   = 2'd1,
      StWarmup = 2'd2,
      StReady  = 2'd3
   } state_e;

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round.
//   state_i : current 288-bit state, bit 0 = s1
//   state_o : state after one round
//   z_o     : keystream bit produced by this round
module trivium_round
   import trivium_pkg::*;
(
   input  logic [STATE_W-1:0] state_i,
   output logic [STATE_W-1:0] state_o,
   output logic               z_o
);

   logic t1, t2, t3;
   logic n1, n2, n3;

   assign t1  = state_i[S66]  ^ state_i[S93];
   assign t2  = state_i[S162] ^ state_i[S177];
   assign t3  = state_i[S243] ^ state_i[S288];
   assign z_o = t1 ^ t2 ^ t3;

   assign n1 = t1 ^ (state_i[S91]  & state_i[S92])  ^ state_i[S171];
   assign n2 = t2 ^ (state_i[S175] & state_i[S176]) ^ state_i[S264];
   assign n3 = t3 ^ (state_i[S286] & state_i[S287]) ^ state_i[S69];

   // Three shift registers: s1..s93 fed by n3, s94..s177 by n1, s178..s288 by n2.
   assign state_o = {state_i[286:177], n2, state_i[175:93], n1, state_i[91:0], n3};

endmodule

// File: rtl/trivium_stream_core.sv
// Parametrised Trivium stream-cipher core.
// Loads an 80-bit key and 80-bit IV in KEY_IN_W-bit words, runs the 1152-round
// warm-up at DATA_W rounds per clock, then XORs DATA_W-bit words with keystream.
// Ports:
//   CLK, RST      clock (rising edge), synchronous active-low reset
//   KEY, STB_KEY  key/IV load word (bit 0 earliest) and its strobe
//   DATA, STB_DATA input word and its strobe
//   READ          consumer takes DATA_OUT this cycle
//   DATA_RDY      STB_DATA would be accepted this cycle
//   DATA_OUT      registered DATA ^ keystream, bit 0 = first keystream bit
//   OUT_VALID     DATA_OUT holds an untaken word
//   SIGN_REG      {3'b0, err_overflow, err_not_ready, OUT_VALID, state[1:0]}
module trivium_stream_core
   import trivium_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned KEY_IN_W = 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [KEY_IN_W-1:0] KEY,
   input  logic                STB_KEY,
   input  logic [DATA_W-1:0]   DATA,
   input  logic                STB_DATA,
   input  logic                READ,
   output logic                DATA_RDY,
   output logic [DATA_W-1:0]   DATA_OUT,
   output logic                OUT_VALID,
   output logic [7:0]          SIGN_REG
);

   localparam int unsigned LoadWords = LOAD_BITS / KEY_IN_W;
   localparam int unsigned WarmClks  = WARMUP_ROUNDS / DATA_W;
   localparam int unsigned LcW       = $clog2(LoadWords);
   localparam int unsigned WcW       = $clog2(WarmClks);

   state_e             state_q, state_d;
   logic [STATE_W-1:0] st_q, st_d;
   logic [LcW-1:0]     load_cnt_q, load_cnt_d;
   logic [WcW-1:0]     warm_cnt_q, warm_cnt_d;
   logic [DATA_W-1:0]  dout_q, dout_d;
   logic               ov_q, ov_d;
   logic               err_nr_q, err_nr_d;
   logic               err_ov_q, err_ov_d;

   logic [STATE_W-1:0] chain [DATA_W+1];
   logic [DATA_W-1:0]  ks;
   logic [STATE_W-1:0] load_state;
   logic [STATE_W-1:0] load_base;
   logic [LcW-1:0]     load_idx;
   logic [8:0]         pos;
   logic               data_rdy;
   logic               accept;

   // DATA_W rounds chained per clock; ks[i] is the i-th keystream bit.
   assign chain[0] = st_q;
   for (genvar i = 0; i < DATA_W; i++) begin : g_round
      trivium_round u_round (
         .state_i (chain[i]),
         .state_o (chain[i+1]),
         .z_o     (ks[i])
      );
   end

   // A strobe outside LOAD starts from an all-zero state at word 0.
   assign load_base = (state_q == StLoad) ? st_q : '0;
   assign load_idx  = (state_q == StLoad) ? load_cnt_q : '0;

   always_comb begin
      load_state = load_base;
      pos        = '0;
      for (int unsigned b = 0; b < KEY_IN_W; b++) begin
         pos = 9'(load_idx * KEY_IN_W + b);
         if (pos < 9'(KEY_BITS)) begin
            load_state[pos] = KEY[b];
         end else begin
            load_state[pos + 9'(IV_GAP)] = KEY[b];
         end
      end
   end

   assign data_rdy = (state_q == StReady) && (!ov_q || READ);
   assign accept   = STB_DATA && data_rdy;

   always_comb begin
      state_d    = state_q;
      st_d       = st_q;
      load_cnt_d = load_cnt_q;
      warm_cnt_d = warm_cnt_q;
      dout_d     = dout_q;
      ov_d       = ov_q;
      err_nr_d   = err_nr_q;
      err_ov_d   = err_ov_q;

      if (STB_KEY) begin
         // Key strobe wins over any data strobe; the data is dropped silently.
         st_d = load_state;
         if (state_q != StLoad) begin
            ov_d       = 1'b0;
            err_nr_d   = 1'b0;
            err_ov_d   = 1'b0;
            load_cnt_d = LcW'(1);
            state_d    = StLoad;
         end else if (load_cnt_q == LcW'(LoadWords - 1)) begin
            st_d[S288:S286] = 3'b111;
            load_cnt_d      = '0;
            warm_cnt_d      = '0;
            state_d         = StWarmup;
         end else begin
            load_cnt_d = load_cnt_q + LcW'(1);
         end
      end else begin
         unique case (state_q)
            StIdle, StLoad: ;
            StWarmup: begin
               st_d = chain[DATA_W];
               if (warm_cnt_q == WcW'(WarmClks - 1)) begin
                  warm_cnt_d = '0;
                  state_d    = StReady;
               end else begin
                  warm_cnt_d = warm_cnt_q + WcW'(1);
               end
            end
            StReady: begin
               if (accept) begin
                  st_d   = chain[DATA_W];
                  dout_d = DATA ^ ks;
                  ov_d   = 1'b1;
               end else if (READ && ov_q) begin
                  ov_d = 1'b0;
               end
            end
            default: ;
         endcase

         if (STB_DATA && !data_rdy) begin
            if (state_q != StReady) begin
               err_nr_d = 1'b1;
            end else begin
               err_ov_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= StIdle;
         st_q       <= '0;
         load_cnt_q <= '0;
         warm_cnt_q <= '0;
         dout_q     <= '0;
         ov_q       <= 1'b0;
         err_nr_q   <= 1'b0;
         err_ov_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         st_q       <= st_d;
         load_cnt_q <= load_cnt_d;
         warm_cnt_q <= warm_cnt_d;
         dout_q     <= dout_d;
         ov_q       <= ov_d;
         err_nr_q   <= err_nr_d;
         err_ov_q   <= err_ov_d;
      end
   end

   assign DATA_RDY  = data_rdy;
   assign DATA_OUT  = dout_q;
   assign OUT_VALID = ov_q;
   assign SIGN_REG  = {3'b000, err_ov_q, err_nr_q, ov_q, state_q};

endmodule

// File: tb/tb_trivium_stream_core.sv
// Bench for trivium_stream_core, run on three width configurations in parallel.
// The reference keystream comes from a bit-level model written on the three
// classic Trivium registers A(93), B(84), C(111).
module tb_trivium_stream_core;

   typedef struct packed {
      logic [93:1]  a;
      logic [84:1]  b;
      logic [111:1] c;
      logic         z;
   } mstate_t;

   typedef struct packed {
      logic        key;
      logic        dat;
      logic        rd;
      logic [63:0] d;
      logic        exp_rdy;
      logic [7:0]  exp_sign;
   } vec_t;

   localparam logic [79:0] KEY_A = 80'h0123456789ABCDEF0123;
   localparam logic [79:0] IV_A  = 80'h89ABCDEF0123456789AB;

   logic clk;
   int   checks;
   int   errors;
   int   n_done;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic mstate_t mstep(input mstate_t m);
      mstate_t r;
      logic t1, t2, t3;
      t1  = m.a[66] ^ m.a[93];
      t2  = m.b[69] ^ m.b[84];
      t3  = m.c[66] ^ m.c[111];
      r.z = t1 ^ t2 ^ t3;
      t1  = t1 ^ (m.a[91] & m.a[92]) ^ m.b[78];
      t2  = t2 ^ (m.b[82] & m.b[83]) ^ m.c[87];
      t3  = t3 ^ (m.c[109] & m.c[110]) ^ m.a[69];
      r.a = {m.a[92:1], t3};
      r.b = {m.b[83:1], t1};
      r.c = {m.c[110:1], t2};
      return r;
   endfunction

   task automatic check(input int cfg, input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL cfg%0d %s: got %h, expected %h", cfg, name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int unsigned DW = (g == 0) ? 8 : ((g == 1) ? 1 : 64);
      localparam int unsigned KW = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
      localparam int unsigned LW = 160 / KW;
      localparam int unsigned WC = 1152 / DW;

      logic          rst;
      logic [KW-1:0] key;
      logic          stb_key;
      logic [DW-1:0] data;
      logic          stb_data;
      logic          read;
      logic          data_rdy;
      logic [DW-1:0] data_out;
      logic          out_valid;
      logic [7:0]    sign_reg;

      mstate_t       m;
      logic [DW-1:0] sbq[$];
      logic [DW-1:0] din  [16];
      logic [DW-1:0] expw [16];
      logic [DW-1:0] got  [16];
      vec_t          tbl  [11];

      trivium_stream_core #(
         .DATA_W   (DW),
         .KEY_IN_W (KW)
      ) u_dut (
         .CLK       (clk),
         .RST       (rst),
         .KEY       (key),
         .STB_KEY   (stb_key),
         .DATA      (data),
         .STB_DATA  (stb_data),
         .READ      (read),
         .DATA_RDY  (data_rdy),
         .DATA_OUT  (data_out),
         .OUT_VALID (out_valid),
         .SIGN_REG  (sign_reg)
      );

      task automatic next_word(output logic [DW-1:0] w);
         for (int i = 0; i < int'(DW); i++) begin
            m    = mstep(m);
            w[i] = m.z;
         end
      endtask

      // Strobes the 160 load bits with an idle gap after some words, then
      // brings the model to the post-warm-up state.
      task automatic load(input logic [79:0] k, input logic [79:0] v);
         logic [159:0] lv;
         lv = {v, k};
         for (int w = 0; w < int'(LW); w++) begin
            key     = lv[w*KW +: KW];
            stb_key = 1'b1;
            @(posedge clk);
            #1;
            stb_key = 1'b0;
            if (w == 0) check(g, "load_state", 64'(sign_reg[1:0]), 64'(2'd1));
            if (w % 3 == 1 && w != int'(LW) - 1) begin
               @(posedge clk);
               #1;
            end
         end
         m.a = {13'b0, lv[79:0]};
         m.b = {4'b0, lv[159:80]};
         m.c = {3'b111, 108'b0};
         m.z = 1'b0;
         for (int i = 0; i < 1152; i++) m = mstep(m);
      endtask

      task automatic warm_check();
         int n = 0;
         int t = 0;
         while (t < 3000) begin
            @(negedge clk);
            if (sign_reg[1:0] == 2'd3) break;
            if (sign_reg[1:0] == 2'd2) n++;
            t++;
         end
         check(g, "warm_clocks", 64'(n), 64'(WC));
         check(g, "ready_rdy", 64'(data_rdy), 64'(1'b1));
         check(g, "ready_sign", 64'(sign_reg), 64'(8'h03));
         @(posedge clk);
         #1;
      endtask

      // 16 back-to-back words with READ held high, then one drain cycle.
      task automatic stream();
         logic [DW-1:0] e;
         for (int i = 0; i <= 16; i++) begin
            stb_data = (i < 16);
            data     = (i < 16) ? din[i] : '0;
            read     = 1'b1;
            @(negedge clk);
            if (i < 16) check(g, $sformatf("strm%0d_rdy", i), 64'(data_rdy), 64'(1'b1));
            if (i > 0) begin
               check(g, $sformatf("strm%0d_valid", i), 64'(out_valid), 64'(1'b1));
               e = sbq.pop_front();
               check(g, $sformatf("strm%0d_dout", i), 64'(data_out), 64'(e));
               got[i-1] = data_out;
            end
            if (i < 16) sbq.push_back(expw[i]);
            @(posedge clk);
            #1;
         end
         stb_data = 1'b0;
         read     = 1'b0;
      endtask

      initial begin
         logic [DW-1:0] w;
         logic [DW-1:0] p;
         logic [63:0]   r;
         rst      = 1'b0;
         key      = '0;
         stb_key  = 1'b0;
         data     = '0;
         stb_data = 1'b0;
         read     = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         @(negedge clk);
         check(g, "rst_sign", 64'(sign_reg), 64'(8'h00));
         check(g, "rst_dout", 64'(data_out), 64'(0));
         check(g, "rst_rdy", 64'(data_rdy), 64'(1'b0));
         rst = 1'b1;
         @(posedge clk);
         #1;

         // All-zero key/IV keystream.
         load('0, '0);
         warm_check();
         for (int i = 0; i < 16; i++) begin
            din[i] = '0;
            next_word(w);
            expw[i] = w;
         end
         stream();

         // Encrypt, reload the same key/IV, decrypt back to the plaintext.
         load(KEY_A, IV_A);
         warm_check();
         for (int i = 0; i < 16; i++) begin
            r      = {$urandom(), $urandom()};
            din[i] = r[DW-1:0];
            next_word(w);
            expw[i] = din[i] ^ w;
         end
         stream();
         load(KEY_A, IV_A);
         warm_check();
         for (int i = 0; i < 16; i++) begin
            p       = din[i];
            din[i]  = got[i];
            expw[i] = p;
            next_word(w);
         end
         stream();

         // Back-pressure, overflow, stalled drain and key/data collision.
         tbl[0]  = '{key:1'b0, dat:1'b1, rd:1'b0, d:64'h11, exp_rdy:1'b1, exp_sign:8'h03};
         tbl[1]  = '{key:1'b0, dat:1'b0, rd:1'b0, d:64'h00, exp_rdy:1'b0, exp_sign:8'h07};
         tbl[2]  = '{key:1'b0, dat:1'b1, rd:1'b0, d:64'h22, exp_rdy:1'b0, exp_sign:8'h07};
         tbl[3]  = '{key:1'b0, dat:1'b0, rd:1'b0, d:64'h00, exp_rdy:1'b0, exp_sign:8'h17};
         tbl[4]  = '{key:1'b0, dat:1'b1, rd:1'b1, d:64'h33, exp_rdy:1'b1, exp_sign:8'h17};
         tbl[5]  = '{key:1'b0, dat:1'b1, rd:1'b1, d:64'h44, exp_rdy:1'b1, exp_sign:8'h17};
         tbl[6]  = '{key:1'b0, dat:1'b0, rd:1'b1, d:64'h00, exp_rdy:1'b1, exp_sign:8'h17};
         tbl[7]  = '{key:1'b0, dat:1'b0, rd:1'b1, d:64'h00, exp_rdy:1'b1, exp_sign:8'h13};
         tbl[8]  = '{key:1'b0, dat:1'b1, rd:1'b0, d:64'h55, exp_rdy:1'b1, exp_sign:8'h13};
         tbl[9]  = '{key:1'b1, dat:1'b1, rd:1'b1, d:64'h66, exp_rdy:1'b1, exp_sign:8'h17};
         tbl[10] = '{key:1'b0, dat:1'b0, rd:1'b0, d:64'h00, exp_rdy:1'b0, exp_sign:8'h01};
         for (int i = 0; i < 11; i++) begin
            stb_key  = tbl[i].key;
            stb_data = tbl[i].dat;
            read     = tbl[i].rd;
            data     = tbl[i].d[DW-1:0];
            key      = '0;
            @(negedge clk);
            check(g, $sformatf("tbl%0d_rdy", i), 64'(data_rdy), 64'(tbl[i].exp_rdy));
            check(g, $sformatf("tbl%0d_sign", i), 64'(sign_reg), 64'(tbl[i].exp_sign));
            if (out_valid) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL cfg%0d tbl%0d_word: got an output word, expected none", g, i);
               end else begin
                  check(g, $sformatf("tbl%0d_dout", i), 64'(data_out), 64'(sbq[0]));
                  if (read) void'(sbq.pop_front());
               end
            end
            if (tbl[i].dat && tbl[i].exp_rdy && !tbl[i].key) begin
               next_word(w);
               sbq.push_back(data ^ w);
            end
            @(posedge clk);
            #1;
         end
         stb_key  = 1'b0;
         stb_data = 1'b0;
         read     = 1'b0;
         check(g, "sb_empty", 64'(sbq.size()), 64'(0));

         // Reset in the middle of a load.
         rst = 1'b0;
         @(posedge clk);
         #1;
         @(negedge clk);
         check(g, "rst_load_sign", 64'(sign_reg), 64'(8'h00));
         check(g, "rst_load_dout", 64'(data_out), 64'(0));
         rst = 1'b1;
         @(posedge clk);
         #1;

         // Reset held for 3 clocks in the middle of warm-up.
         load('0, '0);
         repeat (10) @(posedge clk);
         #1;
         check(g, "mid_warm_state", 64'(sign_reg[1:0]), 64'(2'd2));
         rst = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         @(negedge clk);
         check(g, "rst_warm_sign", 64'(sign_reg), 64'(8'h00));
         check(g, "rst_warm_valid", 64'(out_valid), 64'(1'b0));
         check(g, "rst_warm_rdy", 64'(data_rdy), 64'(1'b0));
         rst = 1'b1;
         @(posedge clk);
         #1;
         stb_data = 1'b1;
         data     = '1;
         @(posedge clk);
         #1;
         stb_data = 1'b0;
         @(negedge clk);
         check(g, "idle_data_err", 64'(sign_reg), 64'(8'h08));
         check(g, "idle_data_dout", 64'(data_out), 64'(0));
         n_done++;
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      n_done = 0;
      for (int t = 0; t < 40000 && n_done < 3; t++) @(posedge clk);
      if (n_done < 3) begin
         errors++;
         $display("FAIL timeout: %0d of 3 configurations finished, required 3", n_done);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
